// File: rtl/ft245_pkg.sv
// Shared types and sizes for the FT245 synchronous-FIFO bus scheduler.
package ft245_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX_OE,
      RX_RD,
      RX_END,
      TX_WR
   } state_t;

   typedef enum logic {
      DIR_RX,
      DIR_TX
   } dir_t;

   localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/ft245_skid.sv
// Two-entry valid/ready FIFO that catches RX bytes already in flight on the
// FT245 bus; reports how many slots are free so reads can be throttled early.
module ft245_skid
   import ft245_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic       valid,
   output logic [7:0] head,
   output logic [1:0] free
);

   logic [7:0] mem [SKID_DEPTH];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       do_push;
   logic       do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'(SKID_DEPTH)) || do_pop);
   assign valid   = (count != 2'd0);
   assign head    = mem[rd_ptr];
   assign free    = 2'(SKID_DEPTH) - count;

   // Pointers and occupancy; a simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

   // Data storage needs no reset; entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ft245_sched.sv
// FT245 synchronous-FIFO bus scheduler: owns OE#/RD#/WR# and the shared data
// bus, arbitrating round-robin between host->FPGA (RX) and FPGA->host (TX)
// with a per-direction burst limit when the other side is waiting.
// Optional build macro FT245_STATS_EN adds rx_bytes/tx_bytes transfer counters.
//
//   state  | meaning
//   IDLE   | bus released, choosing next direction
//   RX_OE  | OE# low, RD# high: one turnaround cycle before reading
//   RX_RD  | OE# low, RD# strobed per byte while skid has room
//   RX_END | OE# back high for one cycle before anyone else drives
//   TX_WR  | FPGA drives data, WR# follows tx_valid
module ft245_sched
   import ft245_pkg::*;
#(
   parameter int MAX_BURST = 16
) (
   input  logic       clk,
   input  logic       _reset,
   input  logic       _txe,
   input  logic       _rxf,
   output logic       _rd,
   output logic       _wr,
   output logic       _oe,
   inout  wire  [7:0] data,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       busy
`ifdef FT245_STATS_EN
   ,
   output logic [31:0] rx_bytes,
   output logic [31:0] tx_bytes
`endif
);

   localparam logic [7:0] MAX_B = 8'(MAX_BURST);

   state_t     state;
   state_t     next_state;
   dir_t       last_dir;
   logic [7:0] burst_cnt;
   logic [7:0] cnt_after;
   logic       oe_q, rd_q, oe_d, rd_d;
   logic [1:0] skid_free;
   logic [2:0] free_after;
   logic       capture, pop, tx_xfer;
   logic       rx_req, tx_req, rd_ok;

   ft245_skid u_skid (
      .clk       (clk),
      .rst_n     (_reset),
      .push      (capture),
      .push_data (data),
      .pop       (pop),
      .valid     (rx_valid),
      .head      (rx_data),
      .free      (skid_free)
   );

   assign data = (state == TX_WR) ? tx_data : 8'bz;
   assign _oe  = oe_q;
   assign _rd  = rd_q;

   assign capture = (state == RX_RD) && !rd_q && !_rxf;
   assign pop     = rx_valid && rx_ready;
   assign tx_xfer = tx_valid && tx_ready;
   assign rx_req  = !_rxf && (skid_free == 2'(SKID_DEPTH));
   assign tx_req  = tx_valid && !_txe;

   // Burst count including this cycle's transfer, saturating at the limit.
   assign cnt_after  = ((capture || tx_xfer) && (burst_cnt < MAX_B)) ? burst_cnt + 8'd1 : burst_cnt;
   assign free_after = 3'(skid_free) + 3'(pop) - 3'(capture);
   // Another strobe is only safe if the skid will be empty, so the byte it
   // fetches always has a slot regardless of what the consumer does.
   assign rd_ok      = !_rxf && (free_after >= 3'd2) && ((cnt_after < MAX_B) || !tx_req);

   // State, registered pin levels, burst counter and round-robin memory.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state     <= IDLE;
         oe_q      <= 1'b1;
         rd_q      <= 1'b1;
         burst_cnt <= 8'd0;
         last_dir  <= DIR_TX;
      end else begin
         state     <= next_state;
         oe_q      <= oe_d;
         rd_q      <= rd_d;
         burst_cnt <= (state == IDLE) ? 8'd0 : cnt_after;
         if (state == RX_END)
            last_dir <= DIR_RX;
         else if ((state == TX_WR) && (next_state == IDLE))
            last_dir <= DIR_TX;
      end
   end

   // Arbitration and burst sequencing.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (rx_req && tx_req)
               next_state = (last_dir == DIR_TX) ? RX_OE : TX_WR;
            else if (rx_req)
               next_state = RX_OE;
            else if (tx_req)
               next_state = TX_WR;
         end
         RX_OE:  next_state = RX_RD;
         RX_RD: begin
            if (_rxf || ((cnt_after >= MAX_B) && tx_req))
               next_state = RX_END;
         end
         RX_END: next_state = IDLE;
         TX_WR: begin
            if (!tx_valid || _txe || ((cnt_after >= MAX_B) && rx_req))
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Pin levels for the next cycle plus the combinational TX handshake.
   always_comb begin
      oe_d     = !((next_state == RX_OE) || (next_state == RX_RD));
      rd_d     = !((next_state == RX_RD) && rd_ok);
      _wr      = !((state == TX_WR) && tx_valid);
      tx_ready = (state == TX_WR) && !_txe;
      busy     = (state != IDLE);
   end

`ifdef FT245_STATS_EN
   // Completed-transfer counters, free-running with natural wrap.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         rx_bytes <= 32'd0;
         tx_bytes <= 32'd0;
      end else begin
         if (capture) rx_bytes <= rx_bytes + 32'd1;
         if (tx_xfer) tx_bytes <= tx_bytes + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ft245_sched.sv
// Directed bench for ft245_sched with a behavioural FT245 on the pins.
module tb_ft245_sched;

   logic       clk = 1'b0;
   logic       _reset, _txe, _rxf, _rd, _wr, _oe;
   logic       tx_valid, tx_ready, rx_valid, rx_ready, busy;
   logic [7:0] tx_data, rx_data;
   wire  [7:0] data;
`ifdef FT245_STATS_EN
   logic [31:0] rx_bytes, tx_bytes;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] h_mem [128];
   int         h_cnt = 0, h_rd = 0;
   logic [7:0] t_mem [128];
   int         t_cnt = 0, t_idx = 0;
   logic [7:0] s_mem [128];
   int         s_cnt = 0;
   logic [7:0] c_mem [128];
   int         c_cnt = 0;
   logic       ev_mem [128];
   int         ev_n = 0, cap_cnt = 0;
   int         occ = 0, ovf = 0, rd_bad = 0, cont = 0;

   always #5 clk = ~clk;

   assign _rxf     = (h_rd >= h_cnt);
   assign data     = !_oe ? h_mem[h_rd[6:0]] : 8'bz;
   assign tx_valid = (t_idx < t_cnt);
   assign tx_data  = t_mem[t_idx[6:0]];

   ft245_sched #(.MAX_BURST(4)) dut (
      .clk      (clk),
      ._reset   (_reset),
      ._txe     (_txe),
      ._rxf     (_rxf),
      ._rd      (_rd),
      ._wr      (_wr),
      ._oe      (_oe),
      .data     (data),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .busy     (busy)
`ifdef FT245_STATS_EN
      ,
      .rx_bytes (rx_bytes),
      .tx_bytes (tx_bytes)
`endif
   );

   // FT245 pin model, TX source, RX consumer and event log.
   always @(posedge clk) begin
      if (!_rd && !_rxf) begin
         h_rd    <= h_rd + 1;
         cap_cnt <= cap_cnt + 1;
         ev_mem[ev_n[6:0]] <= 1'b0;
         ev_n    <= ev_n + 1;
      end else if (!_wr && !_txe) begin
         ev_mem[ev_n[6:0]] <= 1'b1;
         ev_n    <= ev_n + 1;
      end
      if (tx_valid && tx_ready) t_idx <= t_idx + 1;
      if (!_wr && !_txe) begin
         s_mem[s_cnt[6:0]] <= data;
         s_cnt <= s_cnt + 1;
      end
      if (rx_valid && rx_ready) begin
         c_mem[c_cnt[6:0]] <= rx_data;
         c_cnt <= c_cnt + 1;
      end
      if (!_reset) occ <= 0;
      else begin
         if (occ + ((!_rd && !_rxf) ? 1 : 0) - ((rx_valid && rx_ready) ? 1 : 0) > 2) ovf <= ovf + 1;
         occ <= occ + ((!_rd && !_rxf) ? 1 : 0) - ((rx_valid && rx_ready) ? 1 : 0);
      end
   end

   // Bus contention and read-throttle watch.
   always @(negedge clk) begin
      if (!_oe && !_wr) cont <= cont + 1;
      if (!_rd && (occ != 0 || _oe)) rd_bad <= rd_bad + 1;
   end

   task test_reset;
      _reset = 1'b0; _txe = 1'b0; rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({_oe, _rd, _wr, rx_valid, busy, tx_ready} !== 6'b111000) begin
         n_bad++; $display("FAIL reset_pins: got %b want 111000", {_oe, _rd, _wr, rx_valid, busy, tx_ready});
      end
      _reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, _oe} !== 2'b01) begin
         n_bad++; $display("FAIL idle_after_reset: got %b want 01", {busy, _oe});
      end
   endtask

   task test_rx_basic;
      int base, cap0, i;
      logic prev_oe;
      base = c_cnt; cap0 = cap_cnt;
      for (int k = 0; k < 5; k++) h_mem[h_cnt + k] = 8'h11 + 8'(k);
      h_cnt += 5;
      for (i = 0; i < 20 && _oe; i++) @(negedge clk);
      n_cmp++;
      if ({_oe, _rd} !== 2'b01) begin
         n_bad++; $display("FAIL rx_turnaround: got %b want 01", {_oe, _rd});
      end
      @(negedge clk);
      n_cmp++;
      if ({_oe, _rd} !== 2'b00) begin
         n_bad++; $display("FAIL rx_first_rd: got %b want 00", {_oe, _rd});
      end
      prev_oe = 1'b0;
      for (i = 0; i < 80 && busy; i++) begin
         prev_oe = _oe;
         @(negedge clk);
      end
      n_cmp++;
      if ({busy, _oe, prev_oe} !== 3'b011) begin
         n_bad++; $display("FAIL rx_release: got %b want 011", {busy, _oe, prev_oe});
      end
      n_cmp++;
      if (c_cnt - base != 5 || cap_cnt - cap0 != 5) begin
         n_bad++; $display("FAIL rx_basic_count: got %0d/%0d want 5/5", c_cnt - base, cap_cnt - cap0);
      end
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (c_mem[base + k] !== 8'h11 + 8'(k)) begin
            n_bad++; $display("FAIL rx_basic_data[%0d]: got %h want %h", k, c_mem[base + k], 8'h11 + 8'(k));
         end
      end
   endtask

   task test_rx_backpressure;
      int base;
      base = c_cnt;
      for (int k = 0; k < 10; k++) h_mem[h_cnt + k] = 8'h21 + 8'(k);
      h_cnt += 10;
      for (int k = 0; k < 300; k++) begin
         if (c_cnt - base >= 10 && !busy) break;
         rx_ready = ((k / 3) % 2) == 1;
         @(negedge clk);
      end
      rx_ready = 1'b1;
      n_cmp++;
      if (c_cnt - base != 10 || ovf != 0) begin
         n_bad++; $display("FAIL rx_bp_count: got %0d ovf %0d want 10 ovf 0", c_cnt - base, ovf);
      end
      for (int k = 0; k < 10; k++) begin
         n_cmp++;
         if (c_mem[base + k] !== 8'h21 + 8'(k)) begin
            n_bad++; $display("FAIL rx_bp_data[%0d]: got %h want %h", k, c_mem[base + k], 8'h21 + 8'(k));
         end
      end
   endtask

   task test_tx_stall;
      int s0, t0, i;
      s0 = s_cnt; t0 = t_idx;
      for (int k = 0; k < 4; k++) t_mem[t_cnt + k] = 8'hA0 + 8'(k);
      t_cnt += 4;
      for (i = 0; i < 20 && (t_idx - t0 != 2); i++) @(negedge clk);
      _txe = 1'b1;
      #1;
      n_cmp++;
      if (tx_ready !== 1'b0 || t_idx - t0 != 2) begin
         n_bad++; $display("FAIL tx_stall_ready: got ready %b sent %0d want 0/2", tx_ready, t_idx - t0);
      end
      @(negedge clk);
      n_cmp++;
      if ({_wr, busy} !== 2'b10) begin
         n_bad++; $display("FAIL tx_stall_idle: got %b want 10", {_wr, busy});
      end
      @(negedge clk);
      _txe = 1'b0;
      for (i = 0; i < 30 && !(t_idx - t0 == 4 && !busy); i++) @(negedge clk);
      n_cmp++;
      if (s_cnt - s0 != 4) begin
         n_bad++; $display("FAIL tx_count: got %0d want 4", s_cnt - s0);
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (s_mem[s0 + k] !== 8'hA0 + 8'(k)) begin
            n_bad++; $display("FAIL tx_data[%0d]: got %h want %h", k, s_mem[s0 + k], 8'hA0 + 8'(k));
         end
      end
   endtask

   task test_burst_alt;
      int e0, s0, i;
      _reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         h_mem[h_cnt + k] = 8'h31 + 8'(k);
         t_mem[t_cnt + k] = 8'hB0 + 8'(k);
      end
      h_cnt += 8; t_cnt += 8;
      rx_ready = 1'b1; _txe = 1'b0;
      e0 = ev_n; s0 = s_cnt;
      @(negedge clk);
      _reset = 1'b1;
      for (i = 0; i < 300 && !(h_rd == h_cnt && t_idx == t_cnt && !busy && !rx_valid); i++) @(negedge clk);
      n_cmp++;
      if (ev_n - e0 != 16) begin
         n_bad++; $display("FAIL burst_events: got %0d want 16", ev_n - e0);
      end
      for (int k = 0; k < 16; k++) begin
         n_cmp++;
         if (ev_mem[e0 + k] !== (((k / 4) % 2) == 1)) begin
            n_bad++; $display("FAIL burst_order[%0d]: got %b want %b", k, ev_mem[e0 + k], ((k / 4) % 2) == 1);
         end
      end
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if (s_mem[s0 + k] !== 8'hB0 + 8'(k)) begin
            n_bad++; $display("FAIL burst_tx_data[%0d]: got %h want %h", k, s_mem[s0 + k], 8'hB0 + 8'(k));
         end
      end
   endtask

`ifdef FT245_STATS_EN
   task test_stats;
      int i;
      _reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 7; k++) h_mem[h_cnt + k] = 8'h51 + 8'(k);
      for (int k = 0; k < 3; k++) t_mem[t_cnt + k] = 8'hC0 + 8'(k);
      h_cnt += 7; t_cnt += 3;
      @(negedge clk);
      _reset = 1'b1;
      for (i = 0; i < 300 && !(h_rd == h_cnt && t_idx == t_cnt && !busy); i++) @(negedge clk);
      n_cmp++;
      if (rx_bytes !== 32'd7 || tx_bytes !== 32'd3) begin
         n_bad++; $display("FAIL stats: got rx %0d tx %0d want rx 7 tx 3", rx_bytes, tx_bytes);
      end
   endtask
`endif

   task test_reset_mid;
      int c0, i;
      c0 = c_cnt;
      rx_ready = 1'b0;
      for (int k = 0; k < 3; k++) h_mem[h_cnt + k] = 8'h41 + 8'(k);
      h_cnt += 3;
      for (i = 0; i < 20 && !rx_valid; i++) @(negedge clk);
      n_cmp++;
      if ({rx_valid, _oe, busy} !== 3'b101) begin
         n_bad++; $display("FAIL mid_setup: got %b want 101", {rx_valid, _oe, busy});
      end
      _reset = 1'b0;
      #1;
      n_cmp++;
      if ({_oe, _rd, _wr, rx_valid, busy} !== 5'b11100) begin
         n_bad++; $display("FAIL mid_reset_pins: got %b want 11100", {_oe, _rd, _wr, rx_valid, busy});
      end
      @(negedge clk);
      _reset = 1'b1;
      rx_ready = 1'b1;
      for (i = 0; i < 100 && !(h_rd == h_cnt && !busy && !rx_valid); i++) @(negedge clk);
      n_cmp++;
      if (c_cnt - c0 != 2 || c_mem[c0] !== 8'h42 || c_mem[c0 + 1] !== 8'h43) begin
         n_bad++; $display("FAIL mid_discard: got %0d bytes %h %h want 2 bytes 42 43", c_cnt - c0, c_mem[c0], c_mem[c0 + 1]);
      end
   endtask

   initial begin
      test_reset();
      test_rx_basic();
      test_rx_backpressure();
      test_tx_stall();
      test_burst_alt();
`ifdef FT245_STATS_EN
      test_stats();
`endif
      test_reset_mid();
      n_cmp++;
      if (cont != 0 || rd_bad != 0) begin
         n_bad++; $display("FAIL bus_rules: got contention %0d rd_bad %0d want 0 0", cont, rd_bad);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ft245_sched.md
Name: ft245_sched

Overview:
- Bus scheduler that owns the FT245 synchronous-FIFO pins.
- Shares the single bidirectional byte bus between two streams:
  - host->FPGA (RX), delivered as a valid/ready byte stream;
  - FPGA->host (TX), accepted as a valid/ready byte stream.
- Sequences OE#/RD#/WR# with bus turnaround, round-robin arbitration and a per-direction burst limit.
- Sits between the USB pins and the command/readout logic.

Parameters:
- MAX_BURST, 16: bytes moved in one direction before yielding, if the other direction is pending; range 1..255.

Ports:
- clk  in  1  FT245 CLKOUT (60 MHz); sole clock.
- _reset  in  1  asynchronous, active-low reset.
- _txe  in  1  low = FT245 TX FIFO can accept data.
- _rxf  in  1  low = FT245 RX FIFO holds data.
- _rd  out  1  registered; low = read strobe.
- _wr  out  1  low = write strobe.
- _oe  out  1  registered; low = FT245 drives data.
- data  inout  8  FT245 data bus.
- tx_valid  in  1  TX byte offered.
- tx_data  in  8  TX byte.
- tx_ready  out  1  TX byte accepted this cycle.
- rx_valid  out  1  RX byte available.
- rx_data  out  8  RX byte.
- rx_ready  in  1  consumer takes the RX byte.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - _oe=_rd=_wr=1; data tri-stated.
  - rx_valid=0, state=IDLE, burst_cnt=0, skid buffer empty.
  - last_dir=TX, so the first contested grant goes to RX.
- Requests:
  - rx_req = !_rxf && skid buffer empty.
  - tx_req = tx_valid && !_txe.
- States:
  - IDLE: if both requests are pending, grant the direction != last_dir; else grant whichever is pending. RX grant -> RX_OE; TX grant -> TX_WR. burst_cnt is cleared on every grant.
  - RX_OE: _oe=0, _rd=1 for exactly one cycle (turnaround) -> RX_RD.
  - RX_RD: _oe=0. A byte is captured on every rising edge where the sampled _rd=0 and _rxf=0; each capture pushes the 2-entry skid buffer and increments burst_cnt.
    - Next-cycle _rd=0 only if all hold: _rxf=0; skid free slots after this cycle >= 2; and either burst_cnt+1 < MAX_BURST or TX is not pending.
    - Exit to RX_END when _rxf=1, or when burst limit is reached and tx_req.
    - Skid full with _rxf=0: stay in RX_RD with _rd=1 until space frees.
  - RX_END: _oe=1, _rd=1 for one cycle (bus release); last_dir=RX -> IDLE. TX is never driven in the cycle after _oe rises.
  - TX_WR:
    - data = tx_data, driven only in this state.
    - _wr = !tx_valid (combinational); tx_ready = !_txe (combinational).
    - Transfer when tx_valid && tx_ready; burst_cnt++.
    - Exit to IDLE (last_dir=TX) when:
      - tx_valid=0, or
      - _txe=1, or
      - burst_cnt reaches MAX_BURST with rx_req.
      Without a competing request, the burst continues unbounded.
- RX output:
  - rx_valid = skid not empty; rx_data = head entry.
  - Pop when rx_valid && rx_ready.
  - Push and pop in the same cycle keep the count unchanged.
  - Order is preserved; no byte is dropped or duplicated.
- Contention and burst counting:
  - _oe=0 and data driven are never simultaneously true.
  - burst_cnt is 8-bit and saturates at MAX_BURST.
- Reset mid-burst: pins return to idle levels asynchronously; skid contents are discarded.

Optional Feature:
- FT245_STATS_EN: adds outputs rx_bytes[31:0] and tx_bytes[31:0].
  - Increment once per completed transfer; wrap at 2^32; cleared by reset.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ft245_pkg:
  - state enum (IDLE, RX_OE, RX_RD, RX_END, TX_WR);
  - direction enum (DIR_RX, DIR_TX);
  - SKID_DEPTH=2.
- One sub-module, ft245_skid: 2-entry valid/ready FIFO exposing a free-slot count.

Test Plan:
- Host sends 5 bytes 0x11..0x15, rx_ready=1 -> one cycle _oe=0/_rd=1, then _rd low for 5 captures; rx_data sequence 0x11..0x15; RX_END; _oe high before IDLE.
- RX of 10 bytes with rx_ready toggled 0/1 every 3 cycles -> _rd deasserts within 1 cycle of skid nearing full; all 10 bytes delivered in order, no loss.
- tx_valid held with 4 bytes 0xA0..0xA3, _txe forced high on the 3rd byte for 2 cycles -> tx_ready drops, _wr high; exact bytes written once; return to IDLE then resume.
- MAX_BURST=4, both directions continuously pending -> alternation RX 4 bytes, RX_END, TX 4 bytes, RX_OE...; first grant RX.
- Assert _reset mid RX_RD with 1 byte in skid -> _oe/_rd/_wr high immediately, rx_valid=0, busy=0.
- With FT245_STATS_EN: 7 RX and 3 TX transfers -> rx_bytes=7, tx_bytes=3.
